bench_perf_monitor: RTL and testbench
=====================================

Name: bench_perf_monitor

Overview:
- Synthesizable benchmark harness for the superscalar core; instantiated in top_level beside the core.
- Starts on a start pulse and counts cycles and retired instructions across a parametrised commit width.
- Detects program completion (store to TOHOST_ADDR) and a watchdog timeout.
- Latches the result and drives led_out, so benchmarks are read on the board and in simulation with the same logic.

Parameters:
- N_COMMIT, 2, number of commit/retire lanes per cycle (1..8).
- CNT_W, 32, width of the cycle and retired counters.
- TOHOST_ADDR, 32'h0000_1000, store address that signals benchmark completion.
- MAX_CYCLES, 1000, watchdog limit in cycles; must fit in CNT_W bits.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse; begins a run
- commit_valid_in  input  N_COMMIT  per-lane retire valid, this cycle
- store_valid_in  input  1  committed store this cycle
- store_addr_in  input  32  committed store address
- store_data_in  input  32  committed store data
- sel_in  input  2  led_out source select
- cycles_out  output  CNT_W  cycles elapsed in the current/last run
- retired_out  output  CNT_W  instructions retired in the current/last run
- result_out  output  32  data of the halting store
- busy_out  output  1  high in RUN
- done_out  output  1  high in DONE
- timeout_out  output  1  high in TIMEOUT
- led_out  output  16  selected status

Behaviour:
- Clock: one clock, clk_in. Reset: rst_in, synchronous, active-high.
- Reset: state=IDLE; cycles_out, retired_out, result_out = 0; busy_out, done_out, timeout_out = 0; led_out = 0.
- States: IDLE, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start_in:
  - next cycle: state=RUN, counters=0, result_out=0, done_out/timeout_out=0.
  - inputs in the start cycle itself are not counted.
- RUN, every cycle:
  - cycles += 1.
  - retired += popcount(commit_valid_in).
  - both counters saturate at all-ones; no wrap.
- RUN, halt: store_valid_in && store_addr_in==TOHOST_ADDR.
  - result_out <= store_data_in; state <= DONE.
  - the halt cycle's cycle and commits are counted.
  - a non-matching store has no effect.
- RUN, timeout: cycles_out==MAX_CYCLES-1 with no halt -> state <= TIMEOUT.
  - that cycle is counted, so cycles_out==MAX_CYCLES in TIMEOUT.
  - halt and timeout in the same cycle: halt wins (DONE).
- start_in in RUN: ignored.
- DONE/TIMEOUT: counters and result hold until the next start or reset.
- Status outputs are registered and equal the state decode: busy_out=RUN, done_out=DONE, timeout_out=TIMEOUT.
- led_out is registered, one cycle after sel_in or the source changes:
  - sel 0: cycles_out[15:0]
  - sel 1: retired_out[15:0]
  - sel 2: result_out[15:0]
  - sel 3: {13'b0, timeout_out, done_out, busy_out}
- Reset mid-RUN: the next cycle is the full reset state; the partial run is discarded.
- Popcount is combinational, log2(N_COMMIT)+1 bits wide, zero-extended to CNT_W before the add.

Optional Feature:
- Macro: PERF_HIST_EN.
- Defined:
  - N_COMMIT+1 saturating CNT_W-bit bins; bin k counts RUN cycles with exactly k commits.
  - Bins are cleared on start and on reset.
  - Extra ports hist_idx_in (clog2(N_COMMIT+1) bits) and hist_out (CNT_W), registered with one-cycle latency.
  - Invariant in DONE: sum of bins == cycles_out.
- Undefined: no bins and no extra ports; all other behaviour identical.

Decomposition:
- Package perf_pkg:
  - perf_state_t enum {IDLE, RUN, DONE, TIMEOUT}.
  - led_sel_t encodings LED_CYCLES=0, LED_RETIRED=1, LED_RESULT=2, LED_STATUS=3.
  - default TOHOST_ADDR constant.
- Sub-module commit_popcount:
  - parameter N; input N-bit valid vector; output count.
  - purely combinational; reused by the core's ROB stats.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, state IDLE, led_out=0 for every sel.
- Start; 10 RUN cycles with commit_valid=2'b11; then store 0x1000/0x2A -> DONE, cycles_out=11, retired_out=22 (halt cycle also 2'b11), result_out=0x2A, led_out sel2 = 0x002A.
- Start, no halt, MAX_CYCLES=1000 -> timeout_out=1, cycles_out=1000, done_out=0; sel3 -> led_out=16'h0004.
- Halt store on the same cycle cycles_out==999 -> DONE, not TIMEOUT; store to 0x1004 mid-run -> no effect.
- start_in pulsed during RUN -> ignored; rst_in at cycle 5 of a run -> IDLE, counters 0; a fresh start then counts from 0.
- PERF_HIST_EN, N_COMMIT=2, pattern 00,01,11,11 then halt with 00 -> bins {2,1,2}; sum equals cycles_out=5.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the benchmark performance monitor.
// Holds the run-state encoding, led_out source encodings and the default halt address.
// No logic here; imported by the monitor top.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } perf_state_t;

  typedef enum logic [1:0] {
    LED_CYCLES  = 2'd0,
    LED_RETIRED = 2'd1,
    LED_RESULT  = 2'd2,
    LED_STATUS  = 2'd3
  } led_sel_t;

  // Store to this address ends a benchmark run.
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/commit_popcount.sv
// Counts set bits of a per-lane commit-valid vector.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input vector.
module commit_popcount #(
  parameter int N = 2
) (
  input  logic [N-1:0]          valid_i,
  output logic [$clog2(N):0]    count_o
);

  localparam int PC_W = $clog2(N) + 1;

  // Ripple sum over lanes; N is at most 8 so the adder chain stays short.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + PC_W'(valid_i[i]);
    end
  end

endmodule

// File: rtl/bench_perf_monitor.sv
// Benchmark harness: counts cycles/retired instructions from start until tohost store or watchdog.
// Latency: status, counters and result registered (1 cycle); led_out one further cycle.
// Backpressure: none; observes the core every cycle. Optional retire histogram under PERF_HIST_EN.
module bench_perf_monitor
  import perf_pkg::*;
#(
  parameter int          N_COMMIT    = 2,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int          MAX_CYCLES  = 1000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [N_COMMIT-1:0] commit_valid_in,
  input  logic                store_valid_in,
  input  logic [31:0]         store_addr_in,
  input  logic [31:0]         store_data_in,
  input  logic [1:0]          sel_in,
  output logic [CNT_W-1:0]    cycles_out,
  output logic [CNT_W-1:0]    retired_out,
  output logic [31:0]         result_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                timeout_out,
  output logic [15:0]         led_out
`ifdef PERF_HIST_EN
  ,
  input  logic [$clog2(N_COMMIT+1)-1:0] hist_idx_in,
  output logic [CNT_W-1:0]              hist_out
`endif
);

  localparam int PC_W = $clog2(N_COMMIT) + 1;
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  perf_state_t      state_q;
  logic [CNT_W-1:0] cycles_q, retired_q;
  logic [31:0]      result_q;
  logic             busy_q, done_q, timeout_q;
  logic [15:0]      led_q;
  logic [PC_W-1:0]  commit_cnt;
  logic             halt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  commit_popcount #(.N(N_COMMIT)) u_popcount (
    .valid_i (commit_valid_in),
    .count_o (commit_cnt)
  );

  assign halt = store_valid_in && (store_addr_in == TOHOST_ADDR);

  // Run-control FSM with counters, result latch and registered state decode.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cycles_q  <= '0;
      retired_q <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // Every RUN cycle is counted, including the one that ends the run.
          cycles_q  <= sat_add(cycles_q, CNT_W'(1));
          retired_q <= sat_add(retired_q, CNT_W'(commit_cnt));
          if (halt) begin
            result_q <= store_data_in;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (cycles_q == LAST_CYCLE) begin
            state_q   <= TIMEOUT;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          // IDLE, DONE and TIMEOUT all hold their results until a new start.
          if (start_in) begin
            state_q   <= RUN;
            cycles_q  <= '0;
            retired_q <= '0;
            result_q  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // LED mux registered from the already-registered sources.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      led_q <= '0;
    end else begin
      case (led_sel_t'(sel_in))
        LED_CYCLES:  led_q <= cycles_q[15:0];
        LED_RETIRED: led_q <= retired_q[15:0];
        LED_RESULT:  led_q <= result_q[15:0];
        default:     led_q <= {13'b0, timeout_q, done_q, busy_q};
      endcase
    end
  end

  assign cycles_out  = cycles_q;
  assign retired_out = retired_q;
  assign result_out  = result_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign timeout_out = timeout_q;
  assign led_out     = led_q;

`ifdef PERF_HIST_EN
  localparam int HI_W = $clog2(N_COMMIT + 1);

  logic [CNT_W-1:0] bins_q [N_COMMIT+1];
  logic [CNT_W-1:0] hist_q;

  // Bin k counts RUN cycles with exactly k commits; cleared on reset and on start.
  always_ff @(posedge clk_in) begin
    if (rst_in || (state_q != RUN && start_in)) begin
      for (int k = 0; k <= N_COMMIT; k++) bins_q[k] <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k <= N_COMMIT; k++) begin
        if (commit_cnt == PC_W'(k)) bins_q[k] <= sat_add(bins_q[k], CNT_W'(1));
      end
    end
  end

  // Registered bin readout; out-of-range indices read as zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_q <= '0;
    end else begin
      hist_q <= '0;
      for (int k = 0; k <= N_COMMIT; k++) begin
        if (hist_idx_in == HI_W'(k)) hist_q <= bins_q[k];
      end
    end
  end

  assign hist_out = hist_q;
`endif

endmodule

// File: tb/tb_bench_perf_monitor.sv
// Directed bench for bench_perf_monitor with an expected-value queue.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Expected values are queued when the stimulus is applied and popped at the check.
module tb_bench_perf_monitor;

  logic        clk_in = 1'b0;
  logic        rst_in, start_in, store_valid_in;
  logic [1:0]  commit_valid_in, sel_in;
  logic [31:0] store_addr_in, store_data_in;
  logic [31:0] cycles_out, retired_out, result_out;
  logic        busy_out, done_out, timeout_out;
  logic [15:0] led_out;
`ifdef PERF_HIST_EN
  logic [1:0]  hist_idx_in;
  logic [31:0] hist_out;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q [$];

  always #5 clk_in = ~clk_in;

  bench_perf_monitor #(
    .N_COMMIT(2), .CNT_W(32), .TOHOST_ADDR(32'h0000_1000), .MAX_CYCLES(1000)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .commit_valid_in (commit_valid_in),
    .store_valid_in  (store_valid_in),
    .store_addr_in   (store_addr_in),
    .store_data_in   (store_data_in),
    .sel_in          (sel_in),
    .cycles_out      (cycles_out),
    .retired_out     (retired_out),
    .result_out      (result_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .timeout_out     (timeout_out),
    .led_out         (led_out)
`ifdef PERF_HIST_EN
    ,
    .hist_idx_in     (hist_idx_in),
    .hist_out        (hist_out)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; commit_valid_in = 2'b00;
    store_valid_in = 1'b0; store_addr_in = '0; store_data_in = '0; sel_in = 2'd0;
`ifdef PERF_HIST_EN
    hist_idx_in = 2'd0;
`endif
    ticks(2);
    rst_in = 1'b0;

    // Idle after reset: everything zero, LEDs zero for every select.
    ticks(20);
    push(0); push(0); push(0); push(0); push(0); push(0);
    chk("rst_cycles", cycles_out);
    chk("rst_retired", retired_out);
    chk("rst_result", result_out);
    chk("rst_busy", {31'b0, busy_out});
    chk("rst_done", {31'b0, done_out});
    chk("rst_timeout", {31'b0, timeout_out});
    for (int s = 0; s < 4; s++) begin
      sel_in = 2'(s);
      push(0);
      tick();
      chk($sformatf("rst_led_sel%0d", s), {16'b0, led_out});
    end

    // Halt after 10 dual-commit cycles; the halt cycle also commits two.
    sel_in = 2'd2;
    start_run();
    push(1);
    chk("run_busy", {31'b0, busy_out});
    commit_valid_in = 2'b11;
    ticks(10);
    store_valid_in = 1'b1; store_addr_in = 32'h1000; store_data_in = 32'h2A;
    push(1); push(0); push(11); push(22); push(32'h2A);
    tick();
    store_valid_in = 1'b0; commit_valid_in = 2'b00;
    chk("halt_done", {31'b0, done_out});
    chk("halt_busy", {31'b0, busy_out});
    chk("halt_cycles", cycles_out);
    chk("halt_retired", retired_out);
    chk("halt_result", result_out);
    push(32'h002A);
    tick();
    chk("halt_led_result", {16'b0, led_out});
    ticks(3);
    push(11);
    chk("done_hold_cycles", cycles_out);

    // Watchdog run with a non-matching store and a start pulse mid-run.
    sel_in = 2'd3;
    start_run();
    commit_valid_in = 2'b01;
    ticks(100);
    store_valid_in = 1'b1; store_addr_in = 32'h1004; store_data_in = 32'hDEAD;
    tick();
    store_valid_in = 1'b0;
    ticks(100);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    ticks(999 - 202);
    push(999); push(1); push(0);
    chk("pre_to_cycles", cycles_out);
    chk("pre_to_busy", {31'b0, busy_out});
    chk("pre_to_result", result_out);
    push(1); push(0); push(1000); push(1000);
    tick();
    commit_valid_in = 2'b00;
    chk("to_timeout", {31'b0, timeout_out});
    chk("to_done", {31'b0, done_out});
    chk("to_cycles", cycles_out);
    chk("to_retired", retired_out);
    push(32'h0004);
    tick();
    chk("to_led_status", {16'b0, led_out});

    // Halt on the very cycle the watchdog would fire: halt wins.
    start_run();
    ticks(999);
    push(999);
    chk("race_pre_cycles", cycles_out);
    store_valid_in = 1'b1; store_addr_in = 32'h1000; store_data_in = 32'h55;
    push(1); push(0); push(1000); push(32'h55);
    tick();
    store_valid_in = 1'b0;
    chk("race_done", {31'b0, done_out});
    chk("race_timeout", {31'b0, timeout_out});
    chk("race_cycles", cycles_out);
    chk("race_result", result_out);

    // Reset in the middle of a run, then a fresh run counts from zero.
    sel_in = 2'd0;
    start_run();
    commit_valid_in = 2'b11;
    ticks(5);
    rst_in = 1'b1;
    push(0); push(0); push(0); push(0); push(0);
    tick();
    rst_in = 1'b0;
    commit_valid_in = 2'b00;
    chk("midrst_cycles", cycles_out);
    chk("midrst_retired", retired_out);
    chk("midrst_result", result_out);
    chk("midrst_busy", {31'b0, busy_out});
    chk("midrst_led", {16'b0, led_out});
    start_run();
    commit_valid_in = 2'b10;
    ticks(3);
    commit_valid_in = 2'b00;
    push(3); push(3); push(1);
    chk("fresh_cycles", cycles_out);
    chk("fresh_retired", retired_out);
    chk("fresh_busy", {31'b0, busy_out});

`ifdef PERF_HIST_EN
    // Histogram: 00,01,11,11 then halt with 00 -> bins {2,1,2}, sum 5.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    start_run();
    commit_valid_in = 2'b00; tick();
    commit_valid_in = 2'b01; tick();
    commit_valid_in = 2'b11; ticks(2);
    commit_valid_in = 2'b00;
    store_valid_in = 1'b1; store_addr_in = 32'h1000; store_data_in = 32'h7;
    tick();
    store_valid_in = 1'b0;
    push(5);
    chk("hist_cycles", cycles_out);
    begin
      logic [31:0] exp_bins [3];
      logic [31:0] sum;
      exp_bins[0] = 2; exp_bins[1] = 1; exp_bins[2] = 2;
      sum = '0;
      for (int k = 0; k < 3; k++) begin
        hist_idx_in = 2'(k);
        push(exp_bins[k]);
        tick();
        sum = sum + hist_out;
        chk($sformatf("hist_bin%0d", k), hist_out);
      end
      push(cycles_out);
      chk("hist_sum", sum);
    end
`endif

    if (exp_q.size() != 0) begin
      n_total++;
      $error("FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so a broken design cannot hang the run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
